// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer between the execute stage and the CSR file.
// Each accepted request makes at most one write, and flush or reset stops any write that has not yet been issued.
module csr_access_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_src_i,
  input  logic              req_src_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_illegal_o,
  output logic [ADDR_W-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_web_o,
  input  logic              flush_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  // funct3[1:0] selects the operation; funct3[2] only marks the immediate form.
  typedef enum logic [1:0] {OP_NONE, OP_W, OP_S, OP_C} op_kind_t;

  state_t            r_state;
  state_t            w_next_state;
  op_kind_t          r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_src;
  logic              r_src_zero;
  logic              r_illegal;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_new;

  logic              w_accept;
  logic              w_req_wr_intent;
  logic              w_req_illegal;
  logic              w_wr_pending;
  logic [XLEN-1:0]   w_new;

  assign w_accept        = (r_state == IDLE) && req_valid_i && !flush_i;
  assign w_req_wr_intent = (req_op_i[1:0] == 2'b01) || !req_src_zero_i;
  // The top two address bits equal to 2'b11 mark a read-only CSR.
  assign w_req_illegal   = (req_op_i == 3'd0) || (req_op_i == 3'd4) ||
                           ((req_addr_i[ADDR_W-1 -: 2] == 2'b11) && w_req_wr_intent);
  assign w_wr_pending    = (r_kind == OP_W) || !r_src_zero;

  always_comb begin
    unique case (r_kind)
      OP_S:    w_new = csr_rdata_i | r_src;
      OP_C:    w_new = csr_rdata_i & ~r_src;
      default: w_new = r_src;
    endcase
  end

  // NOTE: registers update only with non-blocking assignments, and reset is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: assign the default first so that no path leaves the signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = w_req_illegal ? RESP : READ;
      READ:    w_next_state = w_wr_pending ? WRITE : RESP;
      WRITE:   w_next_state = RESP;
      RESP:    if (rsp_ready_i) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush_i && (r_state != IDLE)) w_next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind     <= OP_NONE;
      r_addr     <= '0;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_illegal  <= 1'b0;
      r_old      <= '0;
      r_new      <= '0;
    end else begin
      if (w_accept) begin
        r_kind     <= op_kind_t'(req_op_i[1:0]);
        r_addr     <= req_addr_i;
        r_src      <= req_src_i;
        r_src_zero <= req_src_zero_i;
        r_illegal  <= w_req_illegal;
        r_old      <= '0;
        r_new      <= '0;
      end
      if (r_state == READ) begin
        r_old <= csr_rdata_i;
        r_new <= w_new;
      end
    end
  end

  // Flush and reset mask the write strobe in the same cycle, so a trap entry in the CSR file never collides with it.
  always_comb begin
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_illegal_o = 1'b0;
    csr_raddr_o   = '0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    csr_web_o     = 1'b0;
    unique case (r_state)
      IDLE:  req_ready_o = !flush_i;
      READ:  csr_raddr_o = r_addr;
      WRITE: begin
        csr_raddr_o = r_addr;
        csr_waddr_o = r_addr;
        csr_wdata_o = r_new;
        csr_web_o   = !flush_i && !rst;
      end
      RESP: begin
        rsp_valid_o   = !flush_i;
        rsp_rdata_o   = r_old;
        rsp_illegal_o = r_illegal;
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != IDLE);

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences Zicsr instructions (CSRRW/S/C and immediate forms) as a read-modify-write transaction against the CSR register file's read port and write port.
- Sits between the execute stage and the CSR file.
- Guarantees one write per accepted instruction and suppresses writes the ISA forbids.
- Aborts in-flight transactions when a trap or flush is raised, so trap entry in the CSR file never collides with an instruction write.

Parameters:
- XLEN, 64, data width of CSR values.
- ADDR_W, 12, CSR address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid_i  input  1  CSR instruction request.
- req_ready_o  output  1  controller can accept a request.
- req_op_i  input  3  funct3: 1=RW, 2=RS, 3=RC, 5=RWI, 6=RSI, 7=RCI.
- req_addr_i  input  ADDR_W  CSR address.
- req_src_i  input  XLEN  rs1 value, or zero-extended uimm for the I forms.
- req_src_zero_i  input  1  rs1 index==0 (or uimm==0).
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_rdata_o  output  XLEN  old CSR value, to be written to rd.
- rsp_illegal_o  output  1  illegal-instruction indication.
- csr_raddr_o  output  ADDR_W  to CSR read port addr.
- csr_rdata_i  input  XLEN  from CSR read port data (combinational read).
- csr_waddr_o  output  ADDR_W  to CSR write port addr.
- csr_wdata_o  output  XLEN  to CSR write port data.
- csr_web_o  output  1  write enable, active-high (1 = write).
- flush_i  input  1  trap entry or pipeline flush; aborts the current transaction.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- States: IDLE, READ, WRITE, RESP. One-hot or binary encoding is acceptable.
- Reset (synchronous; rst high at a clk edge):
  - state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_illegal_o=0; csr_web_o=0; busy_o=0.
  - All address/data outputs and internal latches are 0.
  - rst mid-transaction returns to IDLE with no write issued in the rst cycle.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch op, addr, src and src_zero.
  - Legality check at accept. The request is illegal if:
    - op is 0 or 4, or
    - addr[11:10]==2'b11 (read-only CSR) and a write is intended.
  - A write is intended for RW/RWI always, and for S/C forms only when src_zero=0.
  - Illegal request: go to RESP with rsp_illegal_o=1 and rsp_rdata_o=0. No read or write is issued.
  - Legal request: go to READ.
- READ (one cycle):
  - csr_raddr_o=latched addr; old value is sampled from csr_rdata_i.
  - Computed new value:
    - W: src.
    - S: old | src.
    - C: old & ~src.
  - If a write is intended, go to WRITE; otherwise go to RESP.
- WRITE (one cycle):
  - csr_web_o=1, csr_waddr_o=addr, csr_wdata_o=new value. Exactly one write pulse per transaction.
  - Next state is RESP.
- RESP:
  - rsp_valid_o=1, with rsp_rdata_o=old value and rsp_illegal_o held stable.
  - Hold until rsp_ready_i. In the handshake cycle go to IDLE.
  - req_ready_o=0 in every state except IDLE; no back-to-back accept in the RESP handshake cycle.
- Latency from accept edge to rsp_valid_o:
  - Write transaction: 3 cycles.
  - Read-only transaction: 2 cycles.
  - Illegal request: 1 cycle.
- flush_i:
  - In any non-IDLE state, next state=IDLE, and csr_web_o is forced 0 combinationally in that cycle, even in WRITE.
  - No response is produced, and the pending rsp_valid_o is dropped.
  - In IDLE, flush_i blocks acceptance: req_ready_o=0 while flush_i=1.
  - flush_i and rsp_ready_i together in RESP: flush wins and the response is dropped.
- csr_web_o is 0 in every state other than WRITE.
- csr_raddr_o holds the latched addr in READ and WRITE, and is 0 in IDLE.
- Arithmetic is full XLEN with no width extension beyond zero-extending uimm, which is done upstream.

Test Plan:
- Reset: after rst, CSR 0x340=0. CSRRW addr=0x340, src=0xDEAD_BEEF.
  -> csr_web_o pulses once, 2 cycles after accept, with wdata=0xDEADBEEF.
  -> rsp_rdata_o=0, rsp_valid 3 cycles after accept.
- With mscratch=0xF0, CSRRS addr=0x340, src=0x0F -> wdata=0xFF, rdata=0xF0.
- With mscratch=0xF0, CSRRC src=0x30 -> wdata=0xC0.
- CSRRS with src_zero=1 -> no web pulse; rsp after 2 cycles with rdata=current value.
- CSRRW to 0xF11 (mvendorid) -> rsp_illegal_o=1 after 1 cycle, rdata=0, no read/write.
- CSRRS to 0xF11 with src_zero=1 -> legal; rdata=0.
- op=4 -> illegal.
- flush_i asserted during the WRITE cycle of a CSRRW -> csr_web_o=0 that cycle, busy_o=0 next cycle, no rsp_valid.
- Then a new request is accepted normally.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0 throughout.
- Mid-transaction rst in READ -> IDLE next cycle, no write, all outputs at reset values.
